tt_um_uwasic_onboarding_hyun_jo: RTL and testbench

Tiny Tapeout user-project top for the UWASIC onboarding design: a write-only SPI peripheral (mode 0) feeding five 8-bit control registers that drive 16 digital outputs, each either static or PWM-modulated. Sits directly under the Tiny Tapeout harness; all pins follow the standard `tt_um_*` pinout.

---
 rtl/tt_um_uwasic_onboarding_hyun_jo_pkg.sv | 30 +++
 rtl/tt_um_uwasic_onboarding_hyun_jo_if.sv | 11 +
 rtl/tt_um_uwasic_onboarding_hyun_jo_pwm_peripheral.sv | 42 ++++
 rtl/tt_um_uwasic_onboarding_hyun_jo.sv | 110 +++++++++++
 tb/tb_tt_um_uwasic_onboarding_hyun_jo.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_um_uwasic_onboarding_hyun_jo_pkg.sv
// Shared constants and types for the UWASIC onboarding SPI/PWM design.
package tt_um_uwasic_onboarding_hyun_jo_pkg;

    localparam int unsigned NUM_REGS   = 5;
    localparam int unsigned PRESCALE   = 13;
    localparam int unsigned FRAME_BITS = 16;
    // Bit counter stops here; anything other than FRAME_BITS is a bad frame.
    localparam int unsigned CNT_SAT    = 17;

    typedef enum logic [6:0] {
        ADDR_EN_OUT_LO = 7'h00,
        ADDR_EN_OUT_HI = 7'h01,
        ADDR_EN_PWM_LO = 7'h02,
        ADDR_EN_PWM_HI = 7'h03,
        ADDR_DUTY      = 7'h04
    } reg_addr_e;

    // Layout of one SPI frame as it sits in the shift register, MSB first.
    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } spi_frame_t;

    // A frame is written only when it is a full-length write to a real register.
    function automatic logic frame_commits(input logic [4:0] bit_cnt, input spi_frame_t frame);
        return (bit_cnt == 5'(FRAME_BITS)) && frame.rw && (frame.addr <= ADDR_DUTY);
    endfunction

endpackage

// File: rtl/tt_um_uwasic_onboarding_hyun_jo_if.sv
// Control-register bus carried from the SPI register file to the PWM block.
interface tt_um_uwasic_onboarding_hyun_jo_if;

    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;

    modport master (output en_out, output en_pwm, output duty);
    modport slave  (input  en_out, input  en_pwm, input  duty);

endinterface

// File: rtl/tt_um_uwasic_onboarding_hyun_jo_pwm_peripheral.sv
// Prescaled 8-bit PWM generator with per-pin enable and PWM-select gating.
module pwm_peripheral
    import tt_um_uwasic_onboarding_hyun_jo_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    tt_um_uwasic_onboarding_hyun_jo_if.slave    ctrl,
    output logic [15:0]                         pins
);

    logic [3:0] pre;
    logic [7:0] pcnt;
    logic       pwm;

    // Prescaler divides clk by PRESCALE; pcnt advances once per prescaler wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre  <= '0;
            pcnt <= '0;
        end else if (pre == 4'(PRESCALE - 1)) begin
            pre  <= '0;
            pcnt <= pcnt + 8'd1;
        end else begin
            pre <= pre + 4'd1;
        end
    end

    // Duty 0xFF is forced fully on so the full range reaches both rails.
    always_comb begin
        pwm = (ctrl.duty == 8'hFF) || (pcnt < ctrl.duty);
    end

    // Registered pin drive: disabled pins low, enabled pins static-high or PWM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pins <= '0;
        end else begin
            pins <= ctrl.en_out & (~ctrl.en_pwm | {16{pwm}});
        end
    end

endmodule

// File: rtl/tt_um_uwasic_onboarding_hyun_jo.sv
// Tiny Tapeout top: write-only SPI (mode 0) register file driving 16 PWM/static outputs.
module tt_um_uwasic_onboarding_hyun_jo
    import tt_um_uwasic_onboarding_hyun_jo_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [1:0]  sclk_sync;
    logic [1:0]  copi_sync;
    logic [1:0]  ncs_sync;
    logic        sclk_prev;
    logic        ncs_prev;
    logic        sclk_rise;
    logic        ncs_rise;
    logic        ncs_fall;
    logic        commit;
    logic [4:0]  bit_cnt;
    spi_frame_t  shift_q;
    logic [15:0] en_out_q;
    logic [15:0] en_pwm_q;
    logic [7:0]  duty_q;
    logic [15:0] pins;
    logic        unused;

    tt_um_uwasic_onboarding_hyun_jo_if ctrl_bus ();

    assign unused = &{1'b0, ena, uio_in, ui_in[7:3]};

    // Two-flop synchronizers plus one history flop for edge detection; nCS idles high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], ui_in[0]};
            copi_sync <= {copi_sync[0], ui_in[1]};
            ncs_sync  <= {ncs_sync[0],  ui_in[2]};
            sclk_prev <= sclk_sync[1];
            ncs_prev  <= ncs_sync[1];
        end
    end

    always_comb begin
        sclk_rise = sclk_sync[1] & ~sclk_prev;
        ncs_rise  = ncs_sync[1]  & ~ncs_prev;
        ncs_fall  = ~ncs_sync[1] & ncs_prev;
        commit    = ncs_rise && frame_commits(bit_cnt, shift_q);
    end

    // Shift COPI in on SCLK rise while selected; a SCLK rise coincident with
    // nCS rise is dropped because nCS is already high in the synchronized view.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (ncs_fall) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (!ncs_sync[1] && sclk_rise) begin
            shift_q <= spi_frame_t'({shift_q[14:0], copi_sync[1]});
            if (bit_cnt != 5'(CNT_SAT)) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    // Register file written once per valid frame at nCS rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_out_q <= '0;
            en_pwm_q <= '0;
            duty_q   <= '0;
        end else if (commit) begin
            case (reg_addr_e'(shift_q.addr))
                ADDR_EN_OUT_LO: en_out_q[7:0]  <= shift_q.data;
                ADDR_EN_OUT_HI: en_out_q[15:8] <= shift_q.data;
                ADDR_EN_PWM_LO: en_pwm_q[7:0]  <= shift_q.data;
                ADDR_EN_PWM_HI: en_pwm_q[15:8] <= shift_q.data;
                ADDR_DUTY:      duty_q         <= shift_q.data;
                default: ;
            endcase
        end
    end

    assign ctrl_bus.en_out = en_out_q;
    assign ctrl_bus.en_pwm = en_pwm_q;
    assign ctrl_bus.duty   = duty_q;

    pwm_peripheral u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (ctrl_bus),
        .pins  (pins)
    );

    assign uo_out  = pins[7:0];
    assign uio_out = pins[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_hyun_jo.sv
// Self-checking bench: SPI frames against a register-image and PWM-timing model.
module tb_tt_um_uwasic_onboarding_hyun_jo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        sclk = 1'b0;
    logic        copi = 1'b0;
    logic        ncs = 1'b1;
    logic [7:0]  ui_in;
    logic [7:0]  uio_in;
    logic [7:0]  uo_out;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic [15:0] pins;
    int unsigned cyc;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Expected register image held by the model.
    tt_um_uwasic_onboarding_hyun_jo_if exp_regs ();

    assign ui_in  = {5'b00000, ncs, copi, sclk};
    assign uio_in = 8'h00;
    assign pins   = {uio_out, uo_out};

    tt_um_uwasic_onboarding_hyun_jo dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #50 clk = ~clk;

    // Clock edges elapsed since reset was released.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        exp_regs.en_out = '0;
        exp_regs.en_pwm = '0;
        exp_regs.duty   = '0;
    endtask

    task automatic model_frame(input logic [15:0] word, input int unsigned nbits);
        logic [6:0] addr;
        addr = word[14:8];
        if (nbits == 16 && word[15] && addr <= 7'd4) begin
            case (addr)
                7'd0: exp_regs.en_out[7:0]  = word[7:0];
                7'd1: exp_regs.en_out[15:8] = word[7:0];
                7'd2: exp_regs.en_pwm[7:0]  = word[7:0];
                7'd3: exp_regs.en_pwm[15:8] = word[7:0];
                default: exp_regs.duty      = word[7:0];
            endcase
        end
    endtask

    // Pin value seen after edge cyc: PWM counter is (edges-1)/13 mod 256.
    function automatic logic [15:0] exp_pins();
        int unsigned pc;
        logic p;
        if (cyc == 0) return 16'h0000;
        pc = ((cyc - 1) / 13) % 256;
        p  = (exp_regs.duty == 8'hFF) || (pc < exp_regs.duty);
        return exp_regs.en_out & (~exp_regs.en_pwm | {16{p}});
    endfunction

    // Sends nbits of word MSB-first; simul raises SCLK together with nCS at the end.
    task automatic spi_frame(input logic [15:0] word, input int unsigned nbits, input bit simul,
                             input string tag, output int unsigned lat);
        bit matched;
        @(negedge clk);
        sclk = 1'b0;
        ncs  = 1'b0;
        clks(4);
        for (int unsigned i = 0; i < nbits; i++) begin
            copi = (i < 16) ? word[15 - i] : 1'($urandom);
            clks(4);
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        clks(4);
        if (simul) sclk = 1'b1;
        ncs = 1'b1;
        model_frame(word, nbits);
        matched = 1'b0;
        lat = 99;
        for (int unsigned k = 1; k <= 8 && !matched; k++) begin
            @(negedge clk);
            if (pins === exp_pins()) begin
                matched = 1'b1;
                lat = k;
            end
        end
        sclk = 1'b0;
        clks(2);
        check_eq(tag, 32'(pins), 32'(exp_pins()));
    endtask

    // Finds a rising edge of uo_out[0], then measures its high time and full period.
    task automatic measure_pwm(output int unsigned hi, output int unsigned per, output int unsigned mism);
        logic prev;
        bit found;
        hi = 0; per = 0; mism = 0; found = 1'b0;
        @(negedge clk);
        prev = uo_out[0];
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (pins !== exp_pins()) mism++;
            if (!prev && uo_out[0]) found = 1'b1;
            prev = uo_out[0];
        end
        if (found) begin
            hi = 1;
            for (int i = 0; i < 4000; i++) begin
                @(negedge clk);
                if (pins !== exp_pins()) mism++;
                if (!uo_out[0]) break;
                hi++;
            end
            per = hi + 1;
            for (int i = 0; i < 4000; i++) begin
                @(negedge clk);
                if (pins !== exp_pins()) mism++;
                if (uo_out[0]) break;
                per++;
            end
        end
    endtask

    // Counts cycles where uo_out[0] differs from a constant level, tracking the model too.
    task automatic count_off(input int unsigned n, input logic lvl,
                             output int unsigned off, output int unsigned mism);
        off = 0; mism = 0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            if (uo_out[0] !== lvl) off++;
            if (pins !== exp_pins()) mism++;
        end
    endtask

    initial begin
        int unsigned lat, hi, per, mism, off, nbits;
        int unsigned lens [4];
        logic [15:0] word;
        logic [6:0]  addr;

        lens[0] = 12; lens[1] = 15; lens[2] = 17; lens[3] = 20;
        model_reset();

        // Reset
        rst_n = 1'b0;
        clks(5);
        check_eq("rst_uo_out", 32'(uo_out), 32'h00);
        check_eq("rst_uio_out", 32'(uio_out), 32'h00);
        check_eq("rst_uio_oe", 32'(uio_oe), 32'hFF);
        rst_n = 1'b1;
        clks(3);
        check_eq("idle_pins", 32'(pins), 32'(exp_pins()));

        // Static writes
        spi_frame({1'b1, 7'h00, 8'hF0}, 16, 1'b0, "wr_en_out_lo", lat);
        check_eq("lat_en_out_lo_le4", 32'(lat <= 4), 32'd1);
        check_eq("uo_out_f0", 32'(uo_out), 32'hF0);
        spi_frame({1'b1, 7'h01, 8'hCC}, 16, 1'b0, "wr_en_out_hi", lat);
        check_eq("uio_out_cc", 32'(uio_out), 32'hCC);

        // Rejected frames
        spi_frame({1'b0, 7'h00, 8'hFF}, 16, 1'b0, "rej_read", lat);
        check_eq("rej_read_uo", 32'(uo_out), 32'hF0);
        spi_frame({1'b1, 7'h30, 8'h0F}, 16, 1'b0, "rej_addr", lat);
        check_eq("rej_addr_uo", 32'(uo_out), 32'hF0);
        spi_frame({1'b1, 7'h00, 8'h0F}, 12, 1'b0, "rej_short", lat);
        check_eq("rej_short_uo", 32'(uo_out), 32'hF0);
        spi_frame({1'b1, 7'h00, 8'h0F}, 17, 1'b0, "rej_long", lat);
        check_eq("rej_long_uo", 32'(uo_out), 32'hF0);

        // SCLK rise coincident with nCS rise is not counted, so the frame still commits
        spi_frame({1'b1, 7'h00, 8'hA5}, 16, 1'b1, "simul_edge", lat);
        check_eq("simul_edge_uo", 32'(uo_out), 32'hA5);

        // PWM 50%
        spi_frame({1'b1, 7'h00, 8'h01}, 16, 1'b0, "pwm_setup_en", lat);
        spi_frame({1'b1, 7'h02, 8'h01}, 16, 1'b0, "pwm_setup_sel", lat);
        spi_frame({1'b1, 7'h04, 8'h80}, 16, 1'b0, "pwm_setup_duty", lat);
        measure_pwm(hi, per, mism);
        check_eq("pwm_high", hi, 32'd1664);
        check_eq("pwm_period", per, 32'd3328);
        check_eq("pwm_track", mism, 32'd0);

        // PWM extremes
        spi_frame({1'b1, 7'h04, 8'h00}, 16, 1'b0, "duty_00", lat);
        count_off(2 * 3328 + 100, 1'b0, off, mism);
        check_eq("duty_00_const0", off, 32'd0);
        check_eq("duty_00_track", mism, 32'd0);
        spi_frame({1'b1, 7'h04, 8'hFF}, 16, 1'b0, "duty_ff", lat);
        count_off(2 * 3328 + 100, 1'b1, off, mism);
        check_eq("duty_ff_const1", off, 32'd0);
        check_eq("duty_ff_track", mism, 32'd0);

        // Gating: PWM selected but output disabled
        spi_frame({1'b1, 7'h04, 8'h80}, 16, 1'b0, "gate_duty", lat);
        spi_frame({1'b1, 7'h00, 8'h00}, 16, 1'b0, "gate_en_off", lat);
        spi_frame({1'b1, 7'h02, 8'h01}, 16, 1'b0, "gate_sel", lat);
        count_off(3400, 1'b0, off, mism);
        check_eq("gate_const0", off, 32'd0);
        check_eq("gate_track", mism, 32'd0);

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            addr  = ($urandom_range(0, 9) < 7) ? 7'($urandom_range(0, 4)) : 7'($urandom);
            word  = {($urandom_range(0, 4) != 0), addr, 8'($urandom)};
            nbits = ($urandom_range(0, 5) != 0) ? 16 : lens[$urandom_range(0, 3)];
            spi_frame(word, nbits, 1'b0, "rand_frame", lat);
            clks($urandom_range(1, 40));
            check_eq("rand_track", 32'(pins), 32'(exp_pins()));
        end

        // Reset in the middle of a frame
        spi_frame({1'b1, 7'h00, 8'hFF}, 16, 1'b0, "pre_rst_wr", lat);
        @(negedge clk);
        ncs = 1'b0;
        clks(4);
        for (int unsigned i = 0; i < 8; i++) begin
            copi = 1'($urandom);
            clks(4);
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        clks(3);
        ncs = 1'b1;
        model_reset();
        clks(1);
        rst_n = 1'b1;
        clks(8);
        check_eq("midframe_rst_pins", 32'(pins), 32'h0000);
        spi_frame({1'b1, 7'h01, 8'h3C}, 16, 1'b0, "post_rst_wr", lat);
        check_eq("post_rst_uio", 32'(uio_out), 32'h3C);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
